// File: rtl/mask_drain.sv
// mask_drain: accepts a request mask and emits its set bits one per beat,
// lowest position first, as one-hot plus binary index with a last flag.
module mask_drain #(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned IDXW  = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDXW-1:0]  out_index,
    output logic             out_last,
    output logic             zero_mask
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] low_bit;
    logic [WIDTH-1:0] rem_rest;

    // Lowest set bit of the remaining mask, and the mask with that bit removed.
    always_comb begin
        low_bit  = rem_q & (~rem_q + WIDTH'(1));
        rem_rest = rem_q & (rem_q - WIDTH'(1));
    end

    // State, remaining-mask and zero-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state: accept in IDLE, retire one bit per consumer handshake in DRAIN.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        zero_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_mask == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        rem_d   = in_mask;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    rem_d = rem_rest;
                    if (rem_rest == '0) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // Outputs decoded purely from registered state; index is zero when idle.
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_onehot = '0;
        out_index  = '0;
        out_last   = 1'b0;
        zero_mask  = zero_q;
        if (state_q == S_IDLE) begin
            in_ready = 1'b1;
        end else begin
            out_valid  = 1'b1;
            out_onehot = low_bit;
            out_last   = (rem_rest == '0);
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (low_bit[i]) begin
                    out_index = out_index | IDXW'(i);
                end
            end
        end
    end

endmodule

// File: tb/tb_mask_drain.sv
// Scoreboard bench for mask_drain at WIDTH=4 and WIDTH=8.
module tb_mask_drain;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
    logic [3:0] in_mask4 = '0, out_onehot4;
    logic [1:0] out_index4;
    logic       out_last4, zero_mask4;

    // WIDTH=8 instance
    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
    logic [7:0] in_mask8 = '0, out_onehot8;
    logic [2:0] out_index8;
    logic       out_last8, zero_mask8;

    mask_drain #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_mask(in_mask4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_onehot(out_onehot4), .out_index(out_index4),
        .out_last(out_last4), .zero_mask(zero_mask4)
    );

    mask_drain #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_mask(in_mask8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_onehot(out_onehot8), .out_index(out_index8),
        .out_last(out_last8), .zero_mask(zero_mask8)
    );

    int total = 0;
    int bad   = 0;

    // Expected beats encoded as {last, index[7:0], onehot[7:0]}
    int unsigned q4[$];
    int unsigned q8[$];
    int unsigned e4, e8;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned enc(input int unsigned oh, input int unsigned idx, input bit last);
        return ((last ? 32'd1 : 32'd0) << 16) | (idx << 8) | oh;
    endfunction

    // Reference: ascending set bits, last on the highest one.
    function automatic void push_model(input bit w8, input logic [7:0] m, input int w);
        int hi;
        hi = -1;
        for (int i = 0; i < w; i++) if (m[i]) hi = i;
        for (int i = 0; i < w; i++) begin
            if (m[i]) begin
                if (w8) q8.push_back(enc(32'd1 << i, i, i == hi));
                else    q4.push_back(enc(32'd1 << i, i, i == hi));
            end
        end
    endfunction

    // Monitor: compare each completed WIDTH=4 beat against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                chk("w4_unexpected_beat", {60'd0, out_onehot4}, 64'd0);
            end else begin
                e4 = q4.pop_front();
                chk("w4_onehot", {60'd0, out_onehot4}, {56'd0, e4[7:0]});
                chk("w4_index",  {62'd0, out_index4},  {56'd0, e4[15:8]});
                chk("w4_last",   {63'd0, out_last4},   {63'd0, e4[16]});
            end
        end
    end

    // Monitor: compare each completed WIDTH=8 beat against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_beat", {56'd0, out_onehot8}, 64'd0);
            end else begin
                e8 = q8.pop_front();
                chk("w8_onehot", {56'd0, out_onehot8}, {56'd0, e8[7:0]});
                chk("w8_index",  {61'd0, out_index8},  {56'd0, e8[15:8]});
                chk("w8_last",   {63'd0, out_last8},   {63'd0, e8[16]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one mask to the WIDTH=4 instance for one accepting cycle.
    task automatic send4(input logic [3:0] m);
        chk("w4_ready_before_send", {63'd0, in_ready4}, 64'd1);
        in_valid4 = 1'b1;
        in_mask4  = m;
        tick();
        in_valid4 = 1'b0;
        in_mask4  = 4'b1111;
    endtask

    task automatic drain4_toggling();
        int n;
        n = 0;
        while (q4.size() != 0 && n < 40) begin
            out_ready4 = (n % 3) != 0;
            tick();
            n++;
        end
        chk("w4_drain_pending", 64'(q4.size()), 64'd0);
        chk("w4_ready_after_drain", {63'd0, in_ready4}, 64'd1);
    endtask

    task automatic drain8(input bit toggle);
        int n;
        n = 0;
        while (q8.size() != 0 && n < 60) begin
            out_ready8 = toggle ? ((n % 2) == 0) : 1'b1;
            tick();
            n++;
        end
        chk("w8_drain_pending", 64'(q8.size()), 64'd0);
        chk("w8_ready_after_drain", {63'd0, in_ready8}, 64'd1);
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_in_ready",   {63'd0, in_ready4},  64'd1);
        chk("rst_out_valid",  {63'd0, out_valid4}, 64'd0);
        chk("rst_onehot",     {60'd0, out_onehot4}, 64'd0);
        chk("rst_index",      {62'd0, out_index4}, 64'd0);
        chk("rst_last",       {63'd0, out_last4},  64'd0);
        chk("rst_zero",       {63'd0, zero_mask4}, 64'd0);
        chk("rst8_in_ready",  {63'd0, in_ready8},  64'd1);
        chk("rst8_out_valid", {63'd0, out_valid8}, 64'd0);
        rst_n = 1'b1;
        tick();

        // 1011 with consumer always ready
        out_ready4 = 1'b1;
        q4.push_back(enc(32'h1, 0, 1'b0));
        q4.push_back(enc(32'h2, 1, 1'b0));
        q4.push_back(enc(32'h8, 3, 1'b1));
        send4(4'b1011);
        chk("b1011_valid_lat1", {63'd0, out_valid4}, 64'd1);
        chk("b1011_busy",       {63'd0, in_ready4},  64'd0);
        repeat (3) tick();
        chk("b1011_ready_after", {63'd0, in_ready4},  64'd1);
        chk("b1011_valid_after", {63'd0, out_valid4}, 64'd0);
        chk("b1011_pending",     64'(q4.size()),      64'd0);

        // 0110 with three stalled cycles
        out_ready4 = 1'b0;
        q4.push_back(enc(32'h2, 1, 1'b0));
        q4.push_back(enc(32'h4, 2, 1'b1));
        send4(4'b0110);
        for (int k = 0; k < 3; k++) begin
            chk("stall_onehot", {60'd0, out_onehot4}, 64'h2);
            chk("stall_index",  {62'd0, out_index4},  64'd1);
            chk("stall_last",   {63'd0, out_last4},   64'd0);
            tick();
        end
        out_ready4 = 1'b1;
        repeat (2) tick();
        chk("stall_ready_after", {63'd0, in_ready4}, 64'd1);
        chk("stall_pending",     64'(q4.size()),     64'd0);

        // All-zero mask
        send4(4'b0000);
        chk("zero_pulse",     {63'd0, zero_mask4}, 64'd1);
        chk("zero_no_valid",  {63'd0, out_valid4}, 64'd0);
        chk("zero_ready",     {63'd0, in_ready4},  64'd1);
        tick();
        chk("zero_pulse_end", {63'd0, zero_mask4}, 64'd0);
        chk("zero_no_valid2", {63'd0, out_valid4}, 64'd0);

        // Reset in the middle of draining 1111
        out_ready4 = 1'b1;
        q4.push_back(enc(32'h1, 0, 1'b0));
        q4.push_back(enc(32'h2, 1, 1'b0));
        send4(4'b1111);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid",  {63'd0, out_valid4},  64'd0);
        chk("midrst_ready",  {63'd0, in_ready4},   64'd1);
        chk("midrst_onehot", {60'd0, out_onehot4}, 64'd0);
        chk("midrst_pending", 64'(q4.size()),      64'd0);
        repeat (3) tick();
        chk("midrst_quiet",  {63'd0, out_valid4},  64'd0);

        // Further WIDTH=4 masks with an irregular consumer
        push_model(1'b0, 8'b0000_1100, 4); out_ready4 = 1'b0; send4(4'b1100); drain4_toggling();
        push_model(1'b0, 8'b0000_0101, 4); out_ready4 = 1'b0; send4(4'b0101); drain4_toggling();
        q4.push_back(enc(32'h8, 3, 1'b1));  out_ready4 = 1'b0; send4(4'b1000); drain4_toggling();
        push_model(1'b0, 8'b0000_0111, 4); out_ready4 = 1'b0; send4(4'b0111); drain4_toggling();
        out_ready4 = 1'b0;

        // WIDTH=8: MSB alone, with a new mask held on the input while busy
        out_ready8 = 1'b0;
        q8.push_back(enc(32'h80, 7, 1'b1));
        in_valid8 = 1'b1;
        in_mask8  = 8'h80;
        tick();
        in_mask8  = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            chk("msb_busy",   {63'd0, in_ready8},   64'd0);
            chk("msb_onehot", {56'd0, out_onehot8}, 64'h80);
            chk("msb_index",  {61'd0, out_index8},  64'd7);
            chk("msb_last",   {63'd0, out_last8},   64'd1);
            tick();
        end
        push_model(1'b1, 8'hFF, 8);
        out_ready8 = 1'b1;
        tick();
        chk("msb_ready_after", {63'd0, in_ready8}, 64'd1);
        chk("msb_pending",     64'(q8.size()),     64'd8);
        tick();
        in_valid8 = 1'b0;
        in_mask8  = 8'h00;
        drain8(1'b0);

        // WIDTH=8 mixed mask with a toggling consumer
        push_model(1'b1, 8'b1010_0101, 8);
        out_ready8 = 1'b0;
        in_valid8  = 1'b1;
        in_mask8   = 8'b1010_0101;
        tick();
        in_valid8  = 1'b0;
        in_mask8   = 8'h5A;
        drain8(1'b1);

        out_ready8 = 1'b0;
        tick();
        chk("end_q4_empty", 64'(q4.size()), 64'd0);
        chk("end_q8_empty", 64'(q8.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
